// File: rtl/vip_pkg.sv
// Shared definitions for the dual-camera frame arbiter: FSM encoding,
// pixel width, the default slot length and the slot-length resolver.
package vip_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_PASS     = 2'd2
  } vip_state_e;

  localparam int PIX_W = 16;

  // Frames granted per camera when slot_frames is programmed to 0.
  localparam int unsigned SLOT_DEFAULT = 1;

  // A programmed slot length of 0 means "use the default".
  function automatic logic [3:0] eff_slot(input logic [3:0] slot,
                                          input logic [3:0] dflt);
    return (slot == 4'd0) ? dflt : slot;
  endfunction

endpackage

// File: rtl/vip_sof_detect.sv
// Start-of-frame detector for one camera: flags the cycle where vsync
// rises relative to its registered previous value.
module vip_sof_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_vsync,
  output logic o_sof
);

  logic r_vsync_d;

  // Previous-cycle vsync; cleared on reset so no edge is remembered.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_vsync_d <= 1'b0;
    else       r_vsync_d <= i_vsync;
  end

  assign o_sof = i_vsync & ~r_vsync_d;

endmodule

// File: rtl/vip_frame_arbiter.sv
// Dual-camera frame arbiter. Forwards whole frames from one camera at a
// time to the vip pipeline, switching cameras only at a frame boundary
// so the downstream never sees a truncated frame or a partial vsync.
//
// Handshake: there is no valid/ready back-pressure. The camera streams
// are free-running; a frame is "accepted" when the arbiter observes the
// target camera's vsync rising edge while it is allowed to forward, and
// busy marks every cycle whose pre_* outputs carry forwarded data.
module vip_frame_arbiter
  import vip_pkg::*;
#(
  parameter int unsigned SLOT_DEFAULT = vip_pkg::SLOT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cam0_vsync,
  input  logic             cam0_href,
  input  logic             cam0_de,
  input  logic [PIX_W-1:0] cam0_rgb,
  input  logic             cam1_vsync,
  input  logic             cam1_href,
  input  logic             cam1_de,
  input  logic [PIX_W-1:0] cam1_rgb,
  input  logic [1:0]       cam_en,
  input  logic [3:0]       slot_frames,
  output logic             pre_frame_vsync,
  output logic             pre_frame_href,
  output logic             pre_frame_de,
  output logic [PIX_W-1:0] pre_rgb,
  output logic             cur_cam,
  output logic             sof_pulse,
  output logic             busy,
  output vip_state_e       dbg_state
);

  vip_state_e       r_state;
  logic             r_tgt;
  logic [3:0]       r_fcnt;
  logic             r_vsync;
  logic             r_href;
  logic             r_de;
  logic [PIX_W-1:0] r_rgb;
  logic             r_cur_cam;
  logic             r_sof;
  logic             r_busy;

  logic             w_sof0;
  logic             w_sof1;
  logic             w_sof_tgt;
  logic             w_en_tgt;
  logic             w_en_other;
  logic [3:0]       w_slot_n;
  logic [4:0]       w_fcnt_inc;
  logic             w_fcnt_lt;
  logic [3:0]       w_fcnt_sat;
  logic             w_keep;
  logic             w_sel_vsync;
  logic             w_sel_href;
  logic             w_sel_de;
  logic [PIX_W-1:0] w_sel_rgb;

  vip_sof_detect u_sof0 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_vsync (cam0_vsync),
    .o_sof   (w_sof0)
  );

  vip_sof_detect u_sof1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_vsync (cam1_vsync),
    .o_sof   (w_sof1)
  );

  // Stream of the targeted camera; the other camera is never looked at.
  assign w_sel_vsync = r_tgt ? cam1_vsync : cam0_vsync;
  assign w_sel_href  = r_tgt ? cam1_href  : cam0_href;
  assign w_sel_de    = r_tgt ? cam1_de    : cam0_de;
  assign w_sel_rgb   = r_tgt ? cam1_rgb   : cam0_rgb;
  assign w_sof_tgt   = r_tgt ? w_sof1     : w_sof0;

  assign w_en_tgt    = cam_en[r_tgt];
  assign w_en_other  = cam_en[~r_tgt];

  // Slot length is resolved fresh at every SOF decision.
  assign w_slot_n    = eff_slot(slot_frames, 4'(SLOT_DEFAULT));
  assign w_fcnt_inc  = {1'b0, r_fcnt} + 5'd1;
  assign w_fcnt_lt   = w_fcnt_inc < {1'b0, w_slot_n};
  assign w_fcnt_sat  = (r_fcnt == 4'hF) ? 4'hF : w_fcnt_inc[3:0];
  assign w_keep      = w_en_tgt && (w_fcnt_lt || !w_en_other);

  // Arbitration FSM with registered outputs; data lands one cycle after input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tgt     <= 1'b0;
      r_fcnt    <= 4'd0;
      r_vsync   <= 1'b0;
      r_href    <= 1'b0;
      r_de      <= 1'b0;
      r_rgb     <= '0;
      r_cur_cam <= 1'b0;
      r_sof     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_de    <= 1'b0;
      r_rgb   <= '0;
      r_sof   <= 1'b0;
      r_busy  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cam_en != 2'b00) begin
            r_tgt   <= ~cam_en[0];
            r_state <= ST_WAIT_SOF;
          end
        end
        ST_WAIT_SOF: begin
          if (!w_en_tgt) begin
            r_state <= ST_IDLE;
          end else if (w_sof_tgt) begin
            r_state   <= ST_PASS;
            r_fcnt    <= 4'd0;
            r_vsync   <= w_sel_vsync;
            r_href    <= w_sel_href;
            r_de      <= w_sel_de;
            r_rgb     <= w_sel_rgb;
            r_sof     <= 1'b1;
            r_cur_cam <= r_tgt;
            r_busy    <= 1'b1;
          end
        end
        ST_PASS: begin
          if (!w_sof_tgt || w_keep) begin
            r_vsync <= w_sel_vsync;
            r_href  <= w_sel_href;
            r_de    <= w_sel_de;
            r_rgb   <= w_sel_rgb;
            r_busy  <= 1'b1;
            if (w_sof_tgt) begin
              r_sof  <= 1'b1;
              r_fcnt <= w_fcnt_sat;
            end
          end else if (w_en_other) begin
            r_tgt   <= ~r_tgt;
            r_state <= ST_WAIT_SOF;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pre_frame_vsync = r_vsync;
  assign pre_frame_href  = r_href;
  assign pre_frame_de    = r_de;
  assign pre_rgb         = r_rgb;
  assign cur_cam         = r_cur_cam;
  assign sof_pulse       = r_sof;
  assign busy            = r_busy;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_vip_frame_arbiter.sv
// Directed bench for vip_frame_arbiter. Two free-running synthetic cameras
// (24-cycle frames, 2-cycle vsync, two 4-pixel lines) drive the DUT; each
// test resets, programs cam_en/slot_frames and camera phase offsets, then
// checks the order of forwarded frames, the forwarded DE count, the
// cycle-exact forwarding and vsync integrity against hand-derived values.
module tb_vip_frame_arbiter;
  import vip_pkg::*;

  localparam int P      = 24;
  localparam int VS_LEN = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             cam0_vsync, cam0_href, cam0_de;
  logic [PIX_W-1:0] cam0_rgb;
  logic             cam1_vsync, cam1_href, cam1_de;
  logic [PIX_W-1:0] cam1_rgb;
  logic [1:0]       cam_en;
  logic [3:0]       slot_frames;
  logic             pre_frame_vsync, pre_frame_href, pre_frame_de;
  logic [PIX_W-1:0] pre_rgb;
  logic             cur_cam, sof_pulse, busy;
  vip_state_e       dbg_state;

  int checks   = 0;
  int failures = 0;

  int   ph0, ph1, fr0, fr1;
  int   data_err, partial, de_cnt, vs_run, sof_seq;
  logic prev_vs;

  vip_frame_arbiter #(.SLOT_DEFAULT(1)) dut (
    .clk             (clk),
    .rst             (rst),
    .cam0_vsync      (cam0_vsync),
    .cam0_href       (cam0_href),
    .cam0_de         (cam0_de),
    .cam0_rgb        (cam0_rgb),
    .cam1_vsync      (cam1_vsync),
    .cam1_href       (cam1_href),
    .cam1_de         (cam1_de),
    .cam1_rgb        (cam1_rgb),
    .cam_en          (cam_en),
    .slot_frames     (slot_frames),
    .pre_frame_vsync (pre_frame_vsync),
    .pre_frame_href  (pre_frame_href),
    .pre_frame_de    (pre_frame_de),
    .pre_rgb         (pre_rgb),
    .cur_cam         (cur_cam),
    .sof_pulse       (sof_pulse),
    .busy            (busy),
    .dbg_state       (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Camera word {vsync, href, de, rgb}; rgb tags camera, frame and phase.
  function automatic logic [18:0] cam_word(input logic cam, input int ph, input int fr);
    logic vs, hr;
    logic [15:0] rgb;
    vs  = (ph < VS_LEN);
    hr  = (ph >= 4 && ph < 8) || (ph >= 12 && ph < 16);
    rgb = {cam, 7'(fr), 8'(ph)};
    return {vs, hr, hr, rgb};
  endfunction

  task automatic clear_acc();
    data_err = 0; partial = 0; de_cnt = 0; vs_run = 0; sof_seq = 1; prev_vs = 1'b0;
  endtask

  // One clock: drive both cameras, then sample the DUT 1 ns after the edge.
  // Forwarded words must equal the inputs of the same edge (1-cycle latency).
  task automatic step();
    logic [18:0] d0, d1, o, e;
    d0 = cam_word(1'b0, ph0, fr0);
    d1 = cam_word(1'b1, ph1, fr1);
    {cam0_vsync, cam0_href, cam0_de, cam0_rgb} = d0;
    {cam1_vsync, cam1_href, cam1_de, cam1_rgb} = d1;
    @(posedge clk);
    #1;
    ph0 = ph0 + 1; if (ph0 == P) begin ph0 = 0; fr0 = fr0 + 1; end
    ph1 = ph1 + 1; if (ph1 == P) begin ph1 = 0; fr1 = fr1 + 1; end
    o = {pre_frame_vsync, pre_frame_href, pre_frame_de, pre_rgb};
    e = (busy === 1'b1) ? (cur_cam ? d1 : d0) : 19'd0;
    if (o !== e) data_err = data_err + 1;
    if (busy !== 1'b1 && sof_pulse !== 1'b0) data_err = data_err + 1;
    if (sof_pulse === 1'b1 && pre_frame_vsync !== 1'b1) data_err = data_err + 1;
    if (pre_frame_vsync === 1'b1 && prev_vs === 1'b0 && sof_pulse !== 1'b1) data_err = data_err + 1;
    if (pre_frame_vsync === 1'b1) vs_run = vs_run + 1;
    else begin
      if (vs_run != 0 && vs_run != VS_LEN) partial = partial + 1;
      vs_run = 0;
    end
    if (pre_frame_de === 1'b1) de_cnt = de_cnt + 1;
    if (sof_pulse === 1'b1) sof_seq = (sof_seq << 1) | int'(cur_cam);
    prev_vs = pre_frame_vsync;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic start(input logic [1:0] en, input logic [3:0] slot, input int p0, input int p1);
    rst = 1'b1; cam_en = 2'b00; slot_frames = slot;
    step(); step();
    rst = 1'b0; cam_en = en;
    ph0 = p0; ph1 = p1; fr0 = 0; fr1 = 0;
    clear_acc();
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_en = 2'b11; slot_frames = 4'd1; ph0 = 0; ph1 = 0; fr0 = 0; fr1 = 0;
    clear_acc();
    step(); step();
    checks++; if (pre_frame_vsync !== 1'b0) begin failures++; $display("FAIL reset_vsync: got %0b expected 0", pre_frame_vsync); end
    checks++; if ({pre_frame_href, pre_frame_de} !== 2'b00) begin failures++; $display("FAIL reset_href_de: got %0b expected 00", {pre_frame_href, pre_frame_de}); end
    checks++; if (pre_rgb !== 16'h0000) begin failures++; $display("FAIL reset_rgb: got %h expected 0000", pre_rgb); end
    checks++; if ({cur_cam, sof_pulse, busy} !== 3'b000) begin failures++; $display("FAIL reset_ctrl: got %b expected 000", {cur_cam, sof_pulse, busy}); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_single_cam();
    start(2'b01, 4'd2, P-3, 13);
    run(72);
    checks++; if (sof_seq !== 'b1000) begin failures++; $display("FAIL single_seq: got %b expected 1000", sof_seq); end
    checks++; if (de_cnt !== 24) begin failures++; $display("FAIL single_de: got %0d expected 24", de_cnt); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL single_data: got %0d errors expected 0", data_err); end
    checks++; if ({busy, cur_cam} !== 2'b10) begin failures++; $display("FAIL single_busy: got %b expected 10", {busy, cur_cam}); end
  endtask

  task automatic test_alternate();
    start(2'b11, 4'd1, P-3, 13);
    run(130);
    checks++; if (sof_seq !== 'b10101) begin failures++; $display("FAIL alt_seq: got %b expected 10101", sof_seq); end
    checks++; if (de_cnt !== 32) begin failures++; $display("FAIL alt_de: got %0d expected 32", de_cnt); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL alt_data: got %0d errors expected 0", data_err); end
    checks++; if (partial !== 0) begin failures++; $display("FAIL alt_vsync: got %0d partial pulses expected 0", partial); end
  endtask

  task automatic test_same_cycle_sof();
    start(2'b11, 4'd1, P-3, P-3);
    run(120);
    checks++; if (sof_seq !== 'b1010) begin failures++; $display("FAIL same_seq: got %b expected 1010", sof_seq); end
    checks++; if (de_cnt !== 24) begin failures++; $display("FAIL same_de: got %0d expected 24", de_cnt); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL same_data: got %0d errors expected 0", data_err); end
  endtask

  task automatic test_slot3();
    start(2'b11, 4'd3, P-3, 13);
    run(160);
    checks++; if (sof_seq !== 'b1000111) begin failures++; $display("FAIL slot3_seq: got %b expected 1000111", sof_seq); end
    checks++; if (de_cnt !== 48) begin failures++; $display("FAIL slot3_de: got %0d expected 48", de_cnt); end
    checks++; if (data_err !== 0 || partial !== 0) begin failures++; $display("FAIL slot3_data: got %0d/%0d errors expected 0/0", data_err, partial); end
  endtask

  task automatic test_slot_default();
    start(2'b11, 4'd0, P-3, 13);
    run(130);
    checks++; if (sof_seq !== 'b10101) begin failures++; $display("FAIL slot0_seq: got %b expected 10101", sof_seq); end
    checks++; if (de_cnt !== 32) begin failures++; $display("FAIL slot0_de: got %0d expected 32", de_cnt); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL slot0_data: got %0d errors expected 0", data_err); end
  endtask

  task automatic test_disable_cam0();
    start(2'b11, 4'd4, P-3, 13);
    run(10);
    cam_en = 2'b10;
    run(70);
    checks++; if (sof_seq !== 'b1011) begin failures++; $display("FAIL dis0_seq: got %b expected 1011", sof_seq); end
    checks++; if (de_cnt !== 24) begin failures++; $display("FAIL dis0_de: got %0d expected 24", de_cnt); end
    checks++; if (data_err !== 0 || partial !== 0) begin failures++; $display("FAIL dis0_data: got %0d/%0d errors expected 0/0", data_err, partial); end
  endtask

  task automatic test_disable_all();
    start(2'b01, 4'd1, P-3, 13);
    run(10);
    cam_en = 2'b00;
    run(30);
    checks++; if (sof_seq !== 'b10) begin failures++; $display("FAIL off_seq: got %b expected 10", sof_seq); end
    checks++; if (de_cnt !== 8) begin failures++; $display("FAIL off_de: got %0d expected 8", de_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL off_busy: got %b expected 0", busy); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL off_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL off_data: got %0d errors expected 0", data_err); end
  endtask

  task automatic test_mid_reset();
    start(2'b01, 4'd1, P-3, 13);
    run(16);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({pre_frame_vsync, pre_frame_href, pre_frame_de, pre_rgb, busy} !== 20'd0) begin failures++; $display("FAIL rst_outputs: got %h expected 0", {pre_frame_vsync, pre_frame_href, pre_frame_de, pre_rgb, busy}); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    run(34);
    checks++; if (sof_seq !== 'b100) begin failures++; $display("FAIL rst_seq: got %b expected 100", sof_seq); end
    checks++; if (de_cnt !== 13) begin failures++; $display("FAIL rst_de: got %0d expected 13", de_cnt); end
    checks++; if (data_err !== 0) begin failures++; $display("FAIL rst_data: got %0d errors expected 0", data_err); end
  endtask

  initial begin
    rst = 1'b1; cam_en = 2'b00; slot_frames = 4'd0;
    ph0 = 0; ph1 = 0; fr0 = 0; fr1 = 0;
    clear_acc();
    test_reset();
    test_single_cam();
    test_alternate();
    test_same_cycle_sof();
    test_slot3();
    test_slot_default();
    test_disable_cam0();
    test_disable_all();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
